// File: rtl/bram_preload_initiator_if.sv
// Bundle of the host command/response stream, the session controls and the PL preload chain.
// The master modport is the initiator's view; the slave modport is the host plus the BRAM chain.
interface bram_preload_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 36
);
    logic              sess_start;
    logic              sess_end;
    logic              sess_active;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [1:0]        cmd_be;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              pl_init_o;
    logic              pl_ena_o;
    logic              pl_ren_o;
    logic [1:0]        pl_wen_o;
    logic [ADDR_W-1:0] pl_addr_o;
    logic [DATA_W-1:0] pl_data_o;
    logic [DATA_W-1:0] pl_data_i;

    modport master (
        input  sess_start, sess_end, cmd_valid, cmd_write, cmd_be, cmd_addr, cmd_wdata,
               rsp_ready, pl_data_i,
        output sess_active, cmd_ready, rsp_valid, rsp_data,
               pl_init_o, pl_ena_o, pl_ren_o, pl_wen_o, pl_addr_o, pl_data_o
    );

    modport slave (
        output sess_start, sess_end, cmd_valid, cmd_write, cmd_be, cmd_addr, cmd_wdata,
               rsp_ready, pl_data_i,
        input  sess_active, cmd_ready, rsp_valid, rsp_data,
               pl_init_o, pl_ena_o, pl_ren_o, pl_wen_o, pl_addr_o, pl_data_o
    );
endinterface

// File: rtl/bram_preload_initiator.sv
// Initiator end of the BRAM preload chain: turns one host command at a time into a single
// PL write or read strobe, waits out the chain read latency and hands the captured word back.
module bram_preload_initiator #(
    parameter int INIT_SETUP = 4,
    parameter int RD_LATENCY = 3,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 36
) (
    input  logic                    prog_clock,
    input  logic                    reset,
    bram_preload_initiator_if.master bus
);
    // One shared down-counter serves INIT, WAIT and END_HOLD; size it for the longer count.
    localparam int CNT_MAX = (INIT_SETUP > RD_LATENCY) ? INIT_SETUP : RD_LATENCY;
    localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_READY, S_WR, S_RD, S_WAIT, S_RESP, S_END_HOLD
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_end_pend;
    logic [1:0]        r_be;
    logic [ADDR_W-1:0] r_pl_addr;
    logic [DATA_W-1:0] r_pl_data;
    logic [DATA_W-1:0] r_rsp_data;

    state_t            w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_end_pend_next;
    logic              w_accept;
    logic              w_capture;
    logic              w_end_req;

    // A close request is either latched earlier or arriving this very cycle.
    assign w_end_req = r_end_pend | bus.sess_end;

    // State register plus command/response capture; reset abandons any access in flight.
    always_ff @(posedge prog_clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_end_pend <= 1'b0;
            r_be       <= 2'b00;
            r_pl_addr  <= '0;
            r_pl_data  <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_end_pend <= w_end_pend_next;
            if (w_accept) begin
                r_be      <= bus.cmd_be;
                r_pl_addr <= bus.cmd_addr;
                if (bus.cmd_write) begin
                    r_pl_data <= bus.cmd_wdata;
                end
            end
            if (w_capture) begin
                r_rsp_data <= bus.pl_data_i;
            end
        end
    end

    // Next-state, counter and pending-close decode.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_end_pend_next = r_end_pend;
        w_accept        = 1'b0;
        w_capture       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_end_pend_next = 1'b0;
                if (bus.sess_start) begin
                    w_state_next = S_INIT;
                    w_cnt_next   = CNT_W'(INIT_SETUP - 1);
                end
            end
            S_INIT: begin
                w_end_pend_next = w_end_req;
                if (r_cnt == '0) begin
                    w_state_next = S_READY;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_READY: begin
                if (bus.cmd_valid) begin
                    // The accepted command runs before any close request is honoured.
                    w_accept        = 1'b1;
                    w_end_pend_next = w_end_req;
                    w_state_next    = bus.cmd_write ? S_WR : S_RD;
                end else if (w_end_req) begin
                    w_end_pend_next = 1'b0;
                    w_state_next    = S_END_HOLD;
                    w_cnt_next      = CNT_W'(INIT_SETUP - 1);
                end
            end
            S_WR: begin
                if (w_end_req) begin
                    w_end_pend_next = 1'b0;
                    w_state_next    = S_END_HOLD;
                    w_cnt_next      = CNT_W'(INIT_SETUP - 1);
                end else begin
                    w_state_next = S_READY;
                end
            end
            S_RD: begin
                w_end_pend_next = w_end_req;
                w_state_next    = S_WAIT;
                w_cnt_next      = CNT_W'(RD_LATENCY - 1);
            end
            S_WAIT: begin
                w_end_pend_next = w_end_req;
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    if (w_end_req) begin
                        w_end_pend_next = 1'b0;
                        w_state_next    = S_END_HOLD;
                        w_cnt_next      = CNT_W'(INIT_SETUP - 1);
                    end else begin
                        w_state_next = S_READY;
                    end
                end else begin
                    w_end_pend_next = w_end_req;
                end
            end
            S_END_HOLD: begin
                w_end_pend_next = 1'b0;
                if (r_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // All outputs come straight from registers so reset clears them without waiting for a clock.
    assign bus.pl_init_o   = (r_state != S_IDLE);
    assign bus.sess_active = (r_state != S_IDLE);
    assign bus.cmd_ready   = (r_state == S_READY);
    assign bus.rsp_valid   = (r_state == S_RESP);
    assign bus.rsp_data    = r_rsp_data;
    assign bus.pl_ena_o    = (r_state == S_WR) || (r_state == S_RD);
    assign bus.pl_ren_o    = (r_state == S_RD);
    assign bus.pl_wen_o    = (r_state == S_WR) ? r_be : 2'b00;
    assign bus.pl_addr_o   = r_pl_addr;
    assign bus.pl_data_o   = r_pl_data;
endmodule

// File: tb/tb_bram_preload_initiator.sv
// Bench for bram_preload_initiator: directed vector table, hand sequences for session timing,
// response back-pressure, late close and mid-read reset, then a randomized write/read-back run
// against a BRAM chain model and a command-level reference memory.
module tb_bram_preload_initiator;
    localparam int INIT_SETUP = 4;
    localparam int RD_LATENCY = 3;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 36;

    logic prog_clock = 1'b0;
    logic reset      = 1'b1;
    always #5 prog_clock = ~prog_clock;

    bram_preload_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bram_preload_initiator #(
        .INIT_SETUP(INIT_SETUP), .RD_LATENCY(RD_LATENCY), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .prog_clock(prog_clock),
        .reset     (reset),
        .bus       (bus.master)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Byte-lane merge: lane 0 is bits 17:0, lane 1 is bits 35:18.
    function automatic logic [35:0] merge(input logic [35:0] o, input logic [35:0] n,
                                          input logic [1:0] be);
        merge = {be[1] ? n[35:18] : o[35:18], be[0] ? n[17:0] : o[17:0]};
    endfunction

    typedef struct {
        logic        write;
        logic [1:0]  be;
        logic [31:0] addr;
        logic [35:0] data;
    } cmd_t;

    logic [35:0] ref_mem   [bit [31:0]];   // contents implied by accepted host commands
    logic [35:0] chain_mem [bit [31:0]];   // contents the PL chain actually received
    cmd_t        acc_q[$];                 // accepted commands awaiting their access cycle
    logic [35:0] rsp_q[$];                 // expected read responses
    int          n_accept = 0;
    int          n_access = 0;
    longint      cyc = 0;

    // Command and response handshakes, seen at the edge that completes them.
    cmd_t        c_acc;
    logic [35:0] e_rsp;
    always @(posedge prog_clock) begin
        cyc++;
        if (!reset) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                c_acc.write = bus.cmd_write;
                c_acc.be    = bus.cmd_be;
                c_acc.addr  = bus.cmd_addr;
                c_acc.data  = bus.cmd_wdata;
                acc_q.push_back(c_acc);
                n_accept++;
                if (c_acc.write) begin
                    ref_mem[c_acc.addr] = merge(ref_mem.exists(c_acc.addr) ? ref_mem[c_acc.addr]
                                                : 36'h0, c_acc.data, c_acc.be);
                    $display("txn write addr=0x%08h be=%b data=0x%09h", c_acc.addr, c_acc.be,
                             c_acc.data);
                end else begin
                    rsp_q.push_back(ref_mem.exists(c_acc.addr) ? ref_mem[c_acc.addr] : 36'h0);
                    $display("txn read  addr=0x%08h", c_acc.addr);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e_rsp = rsp_q.pop_front();
                    chk("rsp_data", bus.rsp_data, e_rsp);
                    $display("txn rsp   data=0x%09h", bus.rsp_data);
                end
            end
        end
    end

    // BRAM chain model: applies PL writes and returns read data RD_LATENCY cycles after the strobe.
    cmd_t        c_pl;
    int          rd_cd = 0;
    logic [35:0] rd_val;
    logic [63:0] rnd;
    always @(negedge prog_clock) begin
        rnd           = {$urandom, $urandom};
        bus.pl_data_i = rnd[35:0];
        if (reset) begin
            rd_cd = 0;
        end else begin
            if (rd_cd > 0) begin
                rd_cd--;
                if (rd_cd == 0) bus.pl_data_i = rd_val;
            end
            if (bus.pl_ena_o) begin
                n_access++;
                if (acc_q.size() == 0) begin
                    chk("stray_access", 1, 0);
                end else begin
                    c_pl = acc_q.pop_front();
                    chk("access_fields", {bus.pl_ren_o, bus.pl_wen_o, bus.pl_addr_o},
                        {!c_pl.write, c_pl.write ? c_pl.be : 2'b00, c_pl.addr});
                    if (c_pl.write) chk("access_wdata", bus.pl_data_o, c_pl.data);
                end
                if (bus.pl_wen_o != 2'b00) begin
                    chain_mem[bus.pl_addr_o] = merge(chain_mem.exists(bus.pl_addr_o) ?
                        chain_mem[bus.pl_addr_o] : 36'h0, bus.pl_data_o, bus.pl_wen_o);
                end
                if (bus.pl_ren_o) begin
                    rd_val = chain_mem.exists(bus.pl_addr_o) ? chain_mem[bus.pl_addr_o] : 36'h0;
                    rd_cd  = RD_LATENCY;
                end
            end else begin
                chk("idle_strobes", {bus.pl_ren_o, bus.pl_wen_o}, 0);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge prog_clock);
    endtask

    // Presents a command and returns on the negedge right after it is accepted, valid still high.
    task automatic send_cmd(input logic w, input logic [1:0] be, input logic [31:0] a,
                            input logic [35:0] d);
        bit done = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_be    = be;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        for (int i = 0; i < 64 && !done; i++) begin
            if (bus.cmd_ready) done = 1;
            tick();
        end
        if (!done) begin
            chk("cmd_ready_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int hold, output logic [35:0] d);
        bit seen = 0;
        d = '0;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (bus.rsp_valid) seen = 1;
            else tick();
        end
        if (!seen) begin
            chk("rsp_valid_timeout", 0, 1);
        end else begin
            tick(hold);
            bus.rsp_ready = 1'b1;
            d = bus.rsp_data;
            tick();
            bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int hold, output logic [35:0] d);
        send_cmd(1'b0, 2'b00, a, 36'h0);
        wait_rsp(hold, d);
    endtask

    task automatic start_session();
        bit up = 0;
        bus.sess_start = 1'b1;
        tick();
        bus.sess_start = 1'b0;
        for (int i = 0; i < 32 && !up; i++) begin
            if (bus.cmd_ready) up = 1;
            else tick();
        end
        if (!up) chk("session_open_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctrl"}, {bus.sess_active, bus.cmd_ready, bus.rsp_valid, bus.pl_init_o,
                              bus.pl_ena_o, bus.pl_ren_o, bus.pl_wen_o}, 0);
        chk({name, "_addr"}, bus.pl_addr_o, 0);
        chk({name, "_data"}, bus.pl_data_o, 0);
        chk({name, "_rsp"},  bus.rsp_data, 0);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  be;
        logic [31:0] addr;
        logic [35:0] data;
        logic [35:0] exp;
    } vec_t;

    vec_t        tbl[12];
    logic [35:0] d;
    logic [31:0] pool[32];
    longint      t0;
    int          lat;

    initial begin
        bus.sess_start = 0; bus.sess_end = 0; bus.cmd_valid = 0; bus.cmd_write = 0;
        bus.cmd_be = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.rsp_ready = 0;

        tbl[0]  = '{1'b1, 2'b11, 32'h0000_5003, 36'h9_ABCD_1234, 36'h0};
        tbl[1]  = '{1'b0, 2'b00, 32'h0000_5003, 36'h0,           36'h9_ABCD_1234};
        tbl[2]  = '{1'b1, 2'b01, 32'h0000_5003, 36'hF_FFFF_FFFF, 36'h0};
        tbl[3]  = '{1'b0, 2'b00, 32'h0000_5003, 36'h0,           36'h9_ABCF_FFFF};
        tbl[4]  = '{1'b1, 2'b10, 32'h0000_5003, 36'h0_0000_0000, 36'h0};
        tbl[5]  = '{1'b0, 2'b00, 32'h0000_5003, 36'h0,           36'h0_0003_FFFF};
        tbl[6]  = '{1'b1, 2'b00, 32'h0000_5003, 36'hF_FFFF_FFFF, 36'h0};
        tbl[7]  = '{1'b0, 2'b00, 32'h0000_5003, 36'h0,           36'h0_0003_FFFF};
        tbl[8]  = '{1'b1, 2'b11, 32'hABCD_EFFF, 36'h5_5555_AAAA, 36'h0};
        tbl[9]  = '{1'b0, 2'b00, 32'hABCD_EFFF, 36'h0,           36'h5_5555_AAAA};
        tbl[10] = '{1'b0, 2'b00, 32'h0000_1FFF, 36'h0,           36'h0};
        tbl[11] = '{1'b0, 2'b00, 32'h0000_4003, 36'h0,           36'h0};

        // Reset state
        tick(3);
        chk_all_zero("reset");
        reset = 1'b0;
        tick(2);

        // Session open timing: pl_init_o the cycle after sess_start, cmd_ready INIT_SETUP later
        bus.sess_start = 1'b1;
        tick();
        bus.sess_start = 1'b0;
        chk("open_init", bus.pl_init_o, 1);
        chk("open_active", bus.sess_active, 1);
        for (int k = 1; k <= INIT_SETUP; k++) begin
            chk("open_ready_low", bus.cmd_ready, 0);
            tick();
        end
        chk("open_ready_c5", bus.cmd_ready, 1);

        // Directed vector table, including partial and no-op writes
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].w) begin
                send_cmd(1'b1, tbl[i].be, tbl[i].addr, tbl[i].data);
                bus.cmd_valid = 1'b0;
                chk("tbl_wr_strobe", {bus.pl_ena_o, bus.pl_wen_o, bus.pl_addr_o, bus.pl_data_o[27:0]},
                    {1'b1, tbl[i].be, tbl[i].addr, tbl[i].data[27:0]});
                chk("tbl_wr_data", bus.pl_data_o, tbl[i].data);
                tick();
                chk("tbl_wr_one_cycle", bus.pl_ena_o, 0);
            end else begin
                do_read(tbl[i].addr, 0, d);
                chk("tbl_rd", d, tbl[i].exp);
            end
        end

        // Read with exact chain latency, then five cycles of response back-pressure
        ref_mem[32'h0000_0100]   = 36'h1_2345_6789;
        chain_mem[32'h0000_0100] = 36'h1_2345_6789;
        send_cmd(1'b0, 2'b00, 32'h0000_0100, 36'h0);
        bus.cmd_valid = 1'b0;
        chk("bp_ren", {bus.pl_ena_o, bus.pl_ren_o, bus.pl_wen_o}, 4'b1100);
        lat = 0;
        while (!bus.rsp_valid && lat < 32) begin
            tick();
            lat++;
        end
        chk("bp_latency", lat, RD_LATENCY + 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold", {bus.rsp_valid, bus.cmd_ready, bus.rsp_data}, {2'b10, 36'h1_2345_6789});
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("bp_release", {bus.rsp_valid, bus.cmd_ready}, 2'b01);

        // sess_end during WAIT: read completes, then INIT_SETUP hold cycles, then IDLE
        send_cmd(1'b0, 2'b00, 32'h0000_5003, 36'h0);
        bus.cmd_valid = 1'b0;
        tick();
        bus.sess_end = 1'b1;
        tick();
        bus.sess_end = 1'b0;
        wait_rsp(2, d);
        chk("late_end_rd", d, 36'h0_0003_FFFF);
        for (int k = 0; k < INIT_SETUP; k++) begin
            chk("late_end_hold", {bus.pl_init_o, bus.cmd_ready, bus.pl_ena_o}, 3'b100);
            tick();
        end
        chk("late_end_idle", {bus.pl_init_o, bus.sess_active}, 2'b00);
        bus.sess_end = 1'b1;
        tick();
        bus.sess_end = 1'b0;
        tick(2);
        chk("end_in_idle_ignored", {bus.pl_init_o, bus.cmd_ready}, 2'b00);

        // Reset during WAIT: everything clears at once, then a fresh session works
        start_session();
        send_cmd(1'b0, 2'b00, 32'h0000_5003, 36'h0);
        bus.cmd_valid = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1 chk_all_zero("mid_reset");
        rsp_q.delete();
        acc_q.delete();
        tick();
        reset = 1'b0;
        tick();
        start_session();
        chk("reopen_ready", bus.cmd_ready, 1);
        bus.sess_start = 1'b1;
        tick();
        bus.sess_start = 1'b0;
        chk("start_while_active", {bus.pl_init_o, bus.cmd_ready}, 2'b11);
        send_cmd(1'b1, 2'b11, 32'h0000_0200, 36'hC_0FFE_E123);
        bus.cmd_valid = 1'b0;
        do_read(32'h0000_0200, 1, d);
        chk("post_reset_rd", d, 36'hC_0FFE_E123);

        // 256 back-to-back random writes, then random read-back
        for (int i = 0; i < 32; i++) begin
            pool[i] = {20'($urandom), 12'($urandom)};
        end
        tick();
        t0 = cyc;
        for (int i = 0; i < 256; i++) begin
            send_cmd(1'b1, 2'($urandom), pool[$urandom_range(0, 31)], 36'({$urandom, $urandom}));
        end
        bus.cmd_valid = 1'b0;
        chk("burst_cycles", 64'(cyc - t0), 64'(2 * 256 - 1));
        for (int i = 0; i < 48; i++) begin
            if (i % 8 == 7) do_read({20'($urandom), 12'($urandom)}, $urandom_range(0, 3), d);
            else do_read(pool[$urandom_range(0, 31)], $urandom_range(0, 3), d);
        end

        bus.sess_end = 1'b1;
        tick();
        bus.sess_end = 1'b0;
        tick(INIT_SETUP + 2);
        chk("final_idle", bus.pl_init_o, 0);
        chk("final_acc_q_empty", acc_q.size(), 0);
        chk("final_rsp_q_empty", rsp_q.size(), 0);
        chk("access_count", n_access, n_accept);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
